// File: rtl/instruction_fetch_queue_if.sv
// Bundle between the fetch queue, instruction memory and decode.
// Handshakes: decode takes the head when out_valid && out_ready in the same
// cycle; memory completes a read when mem_req && mem_ack in the same cycle.
interface instruction_fetch_queue_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        redirect;
  logic [31:0] redirect_address;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instruction;
  logic [31:0] out_pc;

  modport master (
    output mem_req, mem_addr, out_valid, out_instruction, out_pc,
    input  mem_ack, mem_rdata, redirect, redirect_address, out_ready
  );

  modport slave (
    input  mem_req, mem_addr, out_valid, out_instruction, out_pc,
    output mem_ack, mem_rdata, redirect, redirect_address, out_ready
  );
endinterface

// File: rtl/instruction_fetch_queue.sv
// Sequential instruction prefetcher: keeps up to DEPTH fetched words in a
// circular queue and restarts from a new target on redirect.
module instruction_fetch_queue #(
  parameter logic [31:0] RESET_ADDRESS = 32'h0000_0000,
  parameter int          DEPTH         = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  instruction_fetch_queue_if.master  bus,
  output logic                       dbg_state
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {IDLE = 1'b0, FETCH = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [31:0]     fetch_pc;
  logic [CW-1:0]   count;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [31:0]     pc_mem   [DEPTH];
  logic [31:0]     inst_mem [DEPTH];
  logic            push, pop, full;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    full        = (count == CW'(DEPTH));
    bus.mem_req = 1'b0;
    case (state_q)
      IDLE:  state_d = FETCH;
      FETCH: begin
        state_d     = FETCH;
        bus.mem_req = !full && !bus.redirect;
      end
    endcase
    // Both handshakes are gated by redirect, so a redirect cycle never moves data.
    push = bus.mem_req && bus.mem_ack;
    pop  = (count != '0) && bus.out_ready && !bus.redirect;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc <= RESET_ADDRESS;
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i]   <= '0;
        inst_mem[i] <= '0;
      end
    end else if (bus.redirect) begin
      fetch_pc <= {bus.redirect_address[31:2], 2'b00};
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else begin
      if (push) begin
        pc_mem[wr_ptr]   <= fetch_pc;
        inst_mem[wr_ptr] <= bus.mem_rdata;
        wr_ptr           <= wr_ptr + AW'(1);
        fetch_pc         <= fetch_pc + 32'd4;
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign bus.mem_addr        = fetch_pc;
  assign bus.out_valid       = (count != '0);
  assign bus.out_instruction = inst_mem[rd_ptr];
  assign bus.out_pc          = pc_mem[rd_ptr];
  assign dbg_state           = state_q;
endmodule

// File: tb/tb_instruction_fetch_queue.sv
// Directed bench for instruction_fetch_queue: reset, streaming, fill/drain,
// redirect, address wrap, random ack latency and asynchronous reset.
module tb_instruction_fetch_queue;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] key;
  logic        dbg_state, wdbg_state;
  int          n_cmp = 0;
  int          n_err = 0;

  logic [31:0] exp_q[$];
  logic [31:0] exp_fetch;
  logic [31:0] wrap_exp [3];
  int          popped, cycles, wait_cnt;
  logic        model_req, do_push, do_pop;

  instruction_fetch_queue_if bus ();
  instruction_fetch_queue_if wbus ();

  always #5 clk = ~clk;

  // Memory models: data is the address, optionally scrambled by key.
  assign bus.mem_rdata         = bus.mem_addr ^ key;
  assign wbus.mem_rdata        = wbus.mem_addr;
  assign wbus.mem_ack          = 1'b1;
  assign wbus.out_ready        = 1'b1;
  assign wbus.redirect         = 1'b0;
  assign wbus.redirect_address = 32'h0;

  instruction_fetch_queue #(.RESET_ADDRESS(32'h0000_0000), .DEPTH(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  instruction_fetch_queue #(.RESET_ADDRESS(32'hFFFF_FFF8), .DEPTH(4)) dut_wrap (
    .clk       (clk),
    .reset     (reset),
    .bus       (wbus),
    .dbg_state (wdbg_state)
  );

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"},   32'(bus.mem_req), 32'h0);
    check({tag, "_addr"},  bus.mem_addr, 32'h0);
    check({tag, "_valid"}, 32'(bus.out_valid), 32'h0);
    check({tag, "_instr"}, bus.out_instruction, 32'h0);
    check({tag, "_pc"},    bus.out_pc, 32'h0);
    check({tag, "_state"}, 32'(dbg_state), 32'h0);
  endtask

  initial begin
    wrap_exp[0] = 32'hFFFF_FFF8;
    wrap_exp[1] = 32'hFFFF_FFFC;
    wrap_exp[2] = 32'h0000_0000;
    reset = 1'b1;
    key   = 32'h0;
    bus.mem_ack          = 1'b0;
    bus.redirect         = 1'b0;
    bus.redirect_address = 32'h0;
    bus.out_ready        = 1'b0;
    tick;
    tick;

    // Reset values
    check_reset_outputs("rst");
    check("rst_wrap_addr", wbus.mem_addr, 32'hFFFF_FFF8);

    // Streaming with ack tied high and decode always ready
    reset = 1'b0;
    bus.mem_ack   = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    check("a_idle_req", 32'(bus.mem_req), 32'h0);
    tick;
    check("a_first_req",   32'(bus.mem_req), 32'h1);
    check("a_first_addr",  bus.mem_addr, 32'h0);
    check("a_first_valid", 32'(bus.out_valid), 32'h0);
    check("a_state_fetch", 32'(dbg_state), 32'h1);
    tick;
    for (int k = 0; k < 6; k++) begin
      check("a_valid", 32'(bus.out_valid), 32'h1);
      check("a_pc",    bus.out_pc, 32'(4 * k));
      check("a_instr", bus.out_instruction, 32'(4 * k));
      if (k < 3) begin
        check("wrap_pc",    wbus.out_pc, wrap_exp[k]);
        check("wrap_instr", wbus.out_instruction, wrap_exp[k]);
      end
      tick;
    end

    // Fill to DEPTH with decode stalled, then release one slot
    reset = 1'b1;
    bus.mem_ack   = 1'b1;
    bus.out_ready = 1'b0;
    tick;
    reset = 1'b0;
    #1;
    check("b_idle_req", 32'(bus.mem_req), 32'h0);
    for (int k = 0; k < 4; k++) begin
      tick;
      check("b_fill_req",  32'(bus.mem_req), 32'h1);
      check("b_fill_addr", bus.mem_addr, 32'(4 * k));
    end
    tick;
    check("b_full_req",   32'(bus.mem_req), 32'h0);
    check("b_full_addr",  bus.mem_addr, 32'h10);
    check("b_full_pc",    bus.out_pc, 32'h0);
    check("b_full_valid", 32'(bus.out_valid), 32'h1);
    tick;
    check("b_full_req2", 32'(bus.mem_req), 32'h0);
    bus.out_ready = 1'b1;
    #1;
    check("b_pop_req_same", 32'(bus.mem_req), 32'h0);
    tick;
    bus.out_ready = 1'b0;
    #1;
    check("b_resume_req",  32'(bus.mem_req), 32'h1);
    check("b_resume_addr", bus.mem_addr, 32'h10);
    check("b_resume_pc",   bus.out_pc, 32'h4);
    tick;
    check("b_refull_req",  32'(bus.mem_req), 32'h0);
    check("b_refull_addr", bus.mem_addr, 32'h14);

    // Redirect with two entries queued
    key = 32'h5A5A_0000;
    bus.out_ready = 1'b1;
    bus.mem_ack   = 1'b0;
    tick;
    tick;
    bus.out_ready = 1'b0;
    #1;
    check("c_two_valid", 32'(bus.out_valid), 32'h1);
    check("c_two_pc",    bus.out_pc, 32'hC);
    bus.redirect         = 1'b1;
    bus.redirect_address = 32'h0000_0103;
    bus.mem_ack          = 1'b1;
    bus.out_ready        = 1'b1;
    #1;
    check("c_redir_req",  32'(bus.mem_req), 32'h0);
    check("c_redir_addr", bus.mem_addr, 32'h14);
    tick;
    bus.redirect  = 1'b0;
    bus.mem_ack   = 1'b0;
    bus.out_ready = 1'b0;
    #1;
    check("c_after_valid", 32'(bus.out_valid), 32'h0);
    check("c_after_addr",  bus.mem_addr, 32'h100);
    check("c_after_req",   32'(bus.mem_req), 32'h1);
    bus.mem_ack = 1'b1;
    tick;
    bus.mem_ack = 1'b0;
    #1;
    check("c_first_valid", 32'(bus.out_valid), 32'h1);
    check("c_first_pc",    bus.out_pc, 32'h100);
    check("c_first_instr", bus.out_instruction, 32'h100 ^ 32'h5A5A_0000);
    check("c_next_addr",   bus.mem_addr, 32'h104);

    // Random ack latency and decode back-pressure against a queue model
    exp_q.delete();
    exp_q.push_back(32'h100);
    exp_fetch = 32'h104;
    popped    = 0;
    cycles    = 0;
    wait_cnt  = 1;
    while (popped < 1000 && cycles < 20000) begin
      model_req = (exp_q.size() < 4);
      if (model_req) begin
        if (wait_cnt == 0) bus.mem_ack = 1'b1;
        else begin
          bus.mem_ack = 1'b0;
          wait_cnt--;
        end
      end else begin
        bus.mem_ack = 1'($urandom_range(0, 1));
      end
      bus.out_ready = ($urandom_range(0, 3) != 0);
      #1;
      check("d_req",   32'(bus.mem_req), 32'(model_req));
      check("d_addr",  bus.mem_addr, exp_fetch);
      check("d_valid", 32'(bus.out_valid), 32'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
        check("d_pc",    bus.out_pc, exp_q[0]);
        check("d_instr", bus.out_instruction, exp_q[0] ^ key);
      end
      do_pop  = (exp_q.size() != 0) && bus.out_ready;
      do_push = model_req && bus.mem_ack;
      if (do_pop) begin
        void'(exp_q.pop_front());
        popped++;
      end
      if (do_push) begin
        exp_q.push_back(exp_fetch);
        exp_fetch = exp_fetch + 32'd4;
        wait_cnt  = $urandom_range(0, 3);
      end
      cycles++;
      tick;
    end
    check("d_popped", 32'(popped), 32'd1000);

    // Asynchronous reset mid-transfer with three entries queued
    reset = 1'b1;
    bus.mem_ack   = 1'b1;
    bus.out_ready = 1'b0;
    tick;
    reset = 1'b0;
    #1;
    check("e_idle_req", 32'(bus.mem_req), 32'h0);
    tick;
    tick;
    tick;
    tick;
    bus.mem_ack = 1'b0;
    #1;
    check("e_three_valid", 32'(bus.out_valid), 32'h1);
    check("e_three_pc",    bus.out_pc, 32'h0);
    check("e_three_req",   32'(bus.mem_req), 32'h1);
    check("e_three_addr",  bus.mem_addr, 32'hC);
    #2;
    reset = 1'b1;
    #1;
    check_reset_outputs("e_async");
    tick;
    reset = 1'b0;
    #1;
    check("e_idle_req2", 32'(bus.mem_req), 32'h0);
    tick;
    check("e_restart_req",  32'(bus.mem_req), 32'h1);
    check("e_restart_addr", bus.mem_addr, 32'h0);
    bus.mem_ack   = 1'b1;
    bus.out_ready = 1'b1;
    tick;
    check("e_restart_valid", 32'(bus.out_valid), 32'h1);
    check("e_restart_pc",    bus.out_pc, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
